// File: rtl/zeroriscy_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : zeroriscy_fetch_queue                                           |
// | Purpose  : Instruction prefetch queue. Issues word-aligned fetches on the  |
// |            instruction bus (one outstanding at most), buffers returned     |
// |            words in a small FIFO and hands them to the IF stage through a  |
// |            valid/ready handshake. A branch flushes queued and in-flight    |
// |            data and restarts fetching at the new target.                   |
// | Options  : ZERORISCY_FETCH_BYPASS_EN - present a response word to the IF   |
// |            stage in its rvalid cycle when the FIFO is empty.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module zeroriscy_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);

    localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]     DEPTH_C  = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_GNT     = 2'd1,
        WAIT_RVALID  = 2'd2,
        WAIT_ABORTED = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [31:0]       fetch_addr_q, fetch_addr_d;
    logic [31:0]       head_addr_q, head_addr_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];

    logic              outstanding;
    logic              fifo_empty;
    logic [CNT_W:0]    occupancy;
    logic              space_ok;
    logic              bypass;
    logic              resp_keep;
    logic              pop;
    logic              fifo_pop;
    logic              push;
    logic [31:0]       target;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign target      = addr_i & 32'hFFFF_FFFC;
    assign outstanding = (state_q == WAIT_RVALID) || (state_q == WAIT_ABORTED);
    assign fifo_empty  = (count_q == '0);
    // Space is reserved for the in-flight word, so a response always fits.
    assign occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, outstanding};
    assign space_ok    = req_i && (occupancy < DEPTH_C);

`ifdef ZERORISCY_FETCH_BYPASS_EN
    assign bypass = fifo_empty && (state_q == WAIT_RVALID) && !branch_i && instr_rvalid_i;
`else
    assign bypass = 1'b0;
`endif

    // A response is kept only for a live (non-aborted) request and no branch.
    assign resp_keep = instr_rvalid_i && (state_q == WAIT_RVALID) && !branch_i;
    assign valid_o   = (!fifo_empty || bypass) && !branch_i;
    assign pop       = valid_o && ready_i;
    assign fifo_pop  = pop && !bypass;
    assign push      = resp_keep && !(bypass && ready_i);
    assign rdata_o   = bypass ? instr_rdata_i : mem_q[rptr_q];
    assign addr_o    = head_addr_q;
    assign busy_o    = instr_req_o | outstanding;

    // Bus FSM: request issue, grant tracking and abort of in-flight data.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        instr_req_o  = 1'b0;
        instr_addr_o = branch_i ? target : fetch_addr_q;
        if (branch_i) begin
            fetch_addr_d = target;
            if (outstanding && !instr_rvalid_i) begin
                state_d = WAIT_ABORTED;
            end else begin
                state_d     = IDLE;
                instr_req_o = req_i || (state_q == WAIT_GNT);
            end
        end else begin
            case (state_q)
                IDLE:     instr_req_o = space_ok;
                WAIT_GNT: instr_req_o = 1'b1;
                WAIT_RVALID, WAIT_ABORTED: begin
                    if (instr_rvalid_i) begin
                        state_d     = IDLE;
                        instr_req_o = space_ok;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (instr_req_o) begin
            if (instr_gnt_i) begin
                state_d      = WAIT_RVALID;
                fetch_addr_d = instr_addr_o + 32'd4;
            end else begin
                state_d = WAIT_GNT;
            end
        end
    end

    // FIFO bookkeeping: flush on branch, otherwise push/pop and head tracking.
    always_comb begin
        count_d     = count_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        head_addr_d = head_addr_q;
        mem_d       = mem_q;
        if (branch_i) begin
            count_d     = '0;
            rptr_d      = '0;
            wptr_d      = '0;
            head_addr_d = target;
        end else begin
            if (push) begin
                mem_d[wptr_q] = instr_rdata_i;
                wptr_d        = ptr_inc(wptr_q);
            end
            if (fifo_pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            if (pop) begin
                head_addr_d = head_addr_q + 32'd4;
            end
            if (push && !fifo_pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && fifo_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State, pointer and address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rptr_q       <= '0;
            wptr_q       <= '0;
            fetch_addr_q <= '0;
            head_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            fetch_addr_q <= fetch_addr_d;
            head_addr_q  <= head_addr_d;
        end
    end

    // FIFO storage; cleared on reset so rdata_o reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule
`default_nettype wire
